// File: rtl/spi_slave_core.sv
// SPI slave core: oversamples ss/sck/mosi in the clk domain, deserializes
// mosi into DW-bit words and serializes a host-queued word onto miso.
module spi_slave_core #(
  parameter int unsigned DW        = 8,
  parameter logic        CPOL      = 1'b0,
  parameter logic        CPHA      = 1'b0,
  parameter logic        MSB_FIRST = 1'b1,
  parameter logic [31:0] IDLE_WORD = 32'hFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ss,
  input  logic          sck,
  input  logic          mosi,
  output logic          miso,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          busy,
  output logic          underrun,
  output logic          overrun
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t        state, state_next;
  logic [1:0]    ss_sync, sck_sync, mosi_sync;
  logic          ss_prev, sck_prev;
  logic          ss_q, sck_q, mosi_q;
  logic          ss_fall_c, ss_rise_c, sck_edge_c, lead_c, trail_c;
  logic          sample_edge_c, shift_edge_c;
  logic          sample_c, shift_c, complete_c, load_c, start_c, abort_c;
  logic [CW-1:0] cnt;
  logic [DW-1:0] rx_sr, rx_next_c;
  logic [DW-1:0] tx_sr, tx_shift_c, load_word_c;
  logic [DW-1:0] hold_data;
  logic          reload_pending, hold_first;

  assign ss_q   = ss_sync[1];
  assign sck_q  = sck_sync[1];
  assign mosi_q = mosi_sync[1];

  // miso carries the current tx bit only while the frame is active
  assign miso = busy & (MSB_FIRST ? tx_sr[DW-1] : tx_sr[0]);

  // Two-flop synchronizers plus previous-value registers for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_sync   <= '0;
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_prev   <= 1'b0;
      sck_prev  <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[0], ss};
      sck_sync  <= {sck_sync[0], sck};
      mosi_sync <= {mosi_sync[0], mosi};
      ss_prev   <= ss_q;
      sck_prev  <= sck_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Edge decode, next state and per-cycle datapath controls
  always_comb begin
    state_next    = state;
    start_c       = 1'b0;
    abort_c       = 1'b0;
    sample_c      = 1'b0;
    shift_c       = 1'b0;
    complete_c    = 1'b0;
    load_c        = 1'b0;
    ss_fall_c     = ss_prev & ~ss_q;
    ss_rise_c     = ~ss_prev & ss_q;
    sck_edge_c    = sck_q ^ sck_prev;
    lead_c        = sck_edge_c & (sck_q != CPOL);
    trail_c       = sck_edge_c & (sck_q == CPOL);
    sample_edge_c = CPHA ? trail_c : lead_c;
    shift_edge_c  = CPHA ? lead_c : trail_c;
    rx_next_c     = MSB_FIRST ? {rx_sr[DW-2:0], mosi_q} : {mosi_q, rx_sr[DW-1:1]};
    tx_shift_c    = MSB_FIRST ? {tx_sr[DW-2:0], 1'b0} : {1'b0, tx_sr[DW-1:1]};
    load_word_c   = tx_ready ? DW'(IDLE_WORD) : hold_data;
    case (state)
      IDLE: begin
        if (ss_fall_c) begin
          state_next = ACTIVE;
          start_c    = 1'b1;
          load_c     = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise_c) begin
          state_next = IDLE;
          abort_c    = 1'b1;
        end else begin
          sample_c   = sample_edge_c;
          shift_c    = shift_edge_c;
          complete_c = sample_edge_c && (cnt == LAST_BIT);
          load_c     = shift_edge_c && reload_pending;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift registers, bit counter and status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt            <= '0;
      rx_sr          <= '0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      overrun        <= 1'b0;
      underrun       <= 1'b0;
      busy           <= 1'b0;
      tx_sr          <= '0;
      reload_pending <= 1'b0;
      hold_first     <= 1'b0;
    end else begin
      rx_valid <= complete_c;
      overrun  <= complete_c & rx_valid;
      underrun <= load_c & tx_ready;
      busy     <= (state_next == ACTIVE);
      if (start_c) begin
        cnt            <= '0;
        reload_pending <= 1'b0;
        hold_first     <= CPHA;
      end
      if (abort_c) begin
        cnt            <= '0;
        reload_pending <= 1'b0;
        hold_first     <= 1'b0;
      end
      if (sample_c) begin
        rx_sr <= rx_next_c;
        if (complete_c) begin
          rx_data        <= rx_next_c;
          cnt            <= '0;
          reload_pending <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (load_c) tx_sr <= load_word_c;
      // CPHA=1 presents the first bit on the first leading edge, so that edge holds
      if (shift_c) begin
        if (reload_pending)  reload_pending <= 1'b0;
        else if (hold_first) hold_first     <= 1'b0;
        else                 tx_sr          <= tx_shift_c;
      end
    end
  end

  // Tx holding register; a load frees it unless a handshake refills it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_data <= '0;
      tx_ready  <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      hold_data <= tx_data;
      tx_ready  <= 1'b0;
    end else if (load_c && !tx_ready) begin
      tx_ready  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: four slaves share sck/mosi and an OR-ed miso.
module tb_spi_slave_core;

  localparam int HP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  ss = 4'hF;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic [3:0]  tx_valid = 4'h0;
  logic [7:0]  tx_d0 = '0, tx_d1 = '0, tx_d2 = '0;
  logic [15:0] tx_d3 = '0;
  wire  [3:0]  miso_w, tx_ready, rx_valid, busy, underrun, overrun;
  wire  [7:0]  rx_d0, rx_d1, rx_d2;
  wire  [15:0] rx_d3;
  wire         miso_bus = |miso_w;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int last_samp_cyc = 0;
  int rxv_cnt [4];
  int rxv_cyc [4];
  int und_cnt [4];
  int ovr_cnt [4];
  logic [31:0] rx_w [4][8];

  always #5 clk = ~clk;

  spi_slave_core u_s0 (.clk(clk), .rst(rst), .ss(ss[0]), .sck(sck), .mosi(mosi), .miso(miso_w[0]),
    .tx_data(tx_d0), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .rx_data(rx_d0),
    .rx_valid(rx_valid[0]), .busy(busy[0]), .underrun(underrun[0]), .overrun(overrun[0]));

  spi_slave_core u_s1 (.clk(clk), .rst(rst), .ss(ss[1]), .sck(sck), .mosi(mosi), .miso(miso_w[1]),
    .tx_data(tx_d1), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .rx_data(rx_d1),
    .rx_valid(rx_valid[1]), .busy(busy[1]), .underrun(underrun[1]), .overrun(overrun[1]));

  spi_slave_core #(.CPOL(1'b1), .CPHA(1'b1)) u_s2 (.clk(clk), .rst(rst), .ss(ss[2]), .sck(sck),
    .mosi(mosi), .miso(miso_w[2]), .tx_data(tx_d2), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .rx_data(rx_d2), .rx_valid(rx_valid[2]), .busy(busy[2]), .underrun(underrun[2]),
    .overrun(overrun[2]));

  spi_slave_core #(.DW(16), .MSB_FIRST(1'b0)) u_s3 (.clk(clk), .rst(rst), .ss(ss[3]), .sck(sck),
    .mosi(mosi), .miso(miso_w[3]), .tx_data(tx_d3), .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]),
    .rx_data(rx_d3), .rx_valid(rx_valid[3]), .busy(busy[3]), .underrun(underrun[3]),
    .overrun(overrun[3]));

  function automatic logic [31:0] rxd(input int i);
    case (i)
      0:       return {24'h0, rx_d0};
      1:       return {24'h0, rx_d1};
      2:       return {24'h0, rx_d2};
      default: return {16'h0, rx_d3};
    endcase
  endfunction

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid[i] === 1'b1) begin
        rx_w[i][rxv_cnt[i] % 8] <= rxd(i);
        rxv_cnt[i] <= rxv_cnt[i] + 1;
        rxv_cyc[i] <= cyc;
      end
      if (underrun[i] === 1'b1) und_cnt[i] <= und_cnt[i] + 1;
      if (overrun[i] === 1'b1)  ovr_cnt[i] <= ovr_cnt[i] + 1;
    end
  end

  // Hang guard
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Queue a word into slave sel's holding register
  task automatic push(input int sel, input logic [31:0] d);
    int k;
    k = 0;
    while (tx_ready[sel] !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (tx_ready[sel] !== 1'b1) begin
      fails++;
      $display("FAIL push_wait sel=%0d: tx_ready got=%b want=1", sel, tx_ready[sel]);
    end
    case (sel)
      0:       tx_d0 = d[7:0];
      1:       tx_d1 = d[7:0];
      2:       tx_d2 = d[7:0];
      default: tx_d3 = d[15:0];
    endcase
    tx_valid[sel] = 1'b1;
    @(negedge clk);
    tx_valid[sel] = 1'b0;
  endtask

  // SPI master: nw words of dw bits in one ss frame, optionally cut after stop_bits bits
  task automatic spi_frame(input int sel, input int dw, input logic cpol, input logic cpha,
                           input logic msb, input int nw, input logic [31:0] w0,
                           input logic [31:0] w1, input int stop_bits,
                           output logic [31:0] r0, output logic [31:0] r1);
    logic [31:0] wo, ri;
    int b, done;
    r0 = '0;
    r1 = '0;
    done = 0;
    sck = cpol;
    repeat (4) @(negedge clk);
    ss[sel] = 1'b0;
    repeat (HP) @(negedge clk);
    for (int w = 0; w < nw; w++) begin
      wo = (w == 0) ? w0 : w1;
      ri = '0;
      for (int i = 0; i < dw; i++) begin
        if (done < stop_bits) begin
          b = msb ? dw - 1 - i : i;
          if (!cpha) begin
            mosi = wo[b];
            repeat (HP) @(negedge clk);
            sck = ~cpol;
            ri[b] = miso_bus;
            last_samp_cyc = cyc;
            repeat (HP) @(negedge clk);
            sck = cpol;
          end else begin
            sck = ~cpol;
            mosi = wo[b];
            repeat (HP) @(negedge clk);
            sck = cpol;
            ri[b] = miso_bus;
            last_samp_cyc = cyc;
            repeat (HP) @(negedge clk);
          end
          done++;
        end
      end
      if (w == 0) r0 = ri;
      else        r1 = ri;
    end
    repeat (HP) @(negedge clk);
    ss[sel] = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] r0, r1;
    int ub;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    ss[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      repeat (4) @(negedge clk);
      sck = ~sck;
    end
    checks++; if (miso_w[0] !== 1'b0)   begin fails++; $display("FAIL rst_miso got=%b want=0", miso_w[0]); end
    checks++; if (tx_ready[0] !== 1'b1) begin fails++; $display("FAIL rst_tx_ready got=%b want=1", tx_ready[0]); end
    checks++; if (rx_d0 !== 8'h00)      begin fails++; $display("FAIL rst_rx_data got=%h want=00", rx_d0); end
    checks++; if (rx_valid[0] !== 1'b0) begin fails++; $display("FAIL rst_rx_valid got=%b want=0", rx_valid[0]); end
    checks++; if (busy[0] !== 1'b0)     begin fails++; $display("FAIL rst_busy got=%b want=0", busy[0]); end
    checks++; if (underrun[0] !== 1'b0) begin fails++; $display("FAIL rst_underrun got=%b want=0", underrun[0]); end
    checks++; if (overrun[0] !== 1'b0)  begin fails++; $display("FAIL rst_overrun got=%b want=0", overrun[0]); end
    ss[0] = 1'b1;
    sck = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    ub = und_cnt[2];
    spi_frame(2, 8, 1'b1, 1'b1, 1'b1, 1, 32'h00, 32'h00, 99, r0, r1);
    repeat (8) @(negedge clk);
    checks++; if (r0 !== 32'hFF) begin fails++; $display("FAIL idle_word miso got=%h want=ff", r0); end
    checks++; if (und_cnt[2] - ub !== 1) begin fails++; $display("FAIL idle_underrun pulses got=%0d want=1", und_cnt[2] - ub); end
  endtask

  task automatic test_mode0();
    logic [31:0] r0, r1;
    int rb;
    push(0, 32'hA5);
    checks++; if (tx_ready[0] !== 1'b0) begin fails++; $display("FAIL m0_tx_ready_full got=%b want=0", tx_ready[0]); end
    rb = rxv_cnt[0];
    spi_frame(0, 8, 1'b0, 1'b0, 1'b1, 1, 32'h3C, 32'h00, 99, r0, r1);
    repeat (8) @(negedge clk);
    checks++; if (rxv_cnt[0] - rb !== 1) begin fails++; $display("FAIL m0_rx_pulses got=%0d want=1", rxv_cnt[0] - rb); end
    checks++; if (rx_w[0][rb % 8] !== 32'h3C) begin fails++; $display("FAIL m0_rx_data got=%h want=3c", rx_w[0][rb % 8]); end
    checks++; if (rxv_cyc[0] - last_samp_cyc !== 3) begin fails++; $display("FAIL m0_latency got=%0d want=3", rxv_cyc[0] - last_samp_cyc); end
    checks++; if (r0 !== 32'hA5) begin fails++; $display("FAIL m0_miso_word got=%h want=a5", r0); end
    checks++; if (tx_ready[0] !== 1'b1) begin fails++; $display("FAIL m0_tx_ready_empty got=%b want=1", tx_ready[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r0, r1;
    int rb, ub, ob, k;
    logic ok;
    rb = rxv_cnt[2];
    ub = und_cnt[2];
    ob = ovr_cnt[2];
    push(2, 32'h11);
    fork
      spi_frame(2, 8, 1'b1, 1'b1, 1'b1, 2, 32'hF0, 32'h0F, 99, r0, r1);
      begin
        ok = 1'b0;
        for (k = 0; k < 40 && !ok; k++) begin
          @(negedge clk);
          if (busy[2] === 1'b1 && tx_ready[2] === 1'b1) ok = 1'b1;
        end
        checks++; if (!ok) begin fails++; $display("FAIL b2b_first_load got=timeout want=tx_ready"); end
        push(2, 32'h22);
      end
    join
    repeat (8) @(negedge clk);
    checks++; if (rxv_cnt[2] - rb !== 2) begin fails++; $display("FAIL b2b_rx_pulses got=%0d want=2", rxv_cnt[2] - rb); end
    checks++; if (rx_w[2][rb % 8] !== 32'hF0) begin fails++; $display("FAIL b2b_rx0 got=%h want=f0", rx_w[2][rb % 8]); end
    checks++; if (rx_w[2][(rb + 1) % 8] !== 32'h0F) begin fails++; $display("FAIL b2b_rx1 got=%h want=0f", rx_w[2][(rb + 1) % 8]); end
    checks++; if (r0 !== 32'h11) begin fails++; $display("FAIL b2b_miso0 got=%h want=11", r0); end
    checks++; if (r1 !== 32'h22) begin fails++; $display("FAIL b2b_miso1 got=%h want=22", r1); end
    checks++; if (und_cnt[2] - ub !== 0) begin fails++; $display("FAIL b2b_underrun got=%0d want=0", und_cnt[2] - ub); end
    checks++; if (ovr_cnt[2] - ob !== 0) begin fails++; $display("FAIL b2b_overrun got=%0d want=0", ovr_cnt[2] - ob); end
  endtask

  task automatic test_abort();
    logic [31:0] r0, r1;
    int rb;
    rb = rxv_cnt[0];
    spi_frame(0, 8, 1'b0, 1'b0, 1'b1, 1, 32'hFF, 32'h00, 5, r0, r1);
    checks++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL abort_busy_before got=%b want=1", busy[0]); end
    repeat (3) @(negedge clk);
    checks++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL abort_busy_after got=%b want=0", busy[0]); end
    repeat (8) @(negedge clk);
    checks++; if (rxv_cnt[0] - rb !== 0) begin fails++; $display("FAIL abort_rx_pulses got=%0d want=0", rxv_cnt[0] - rb); end
    rb = rxv_cnt[0];
    spi_frame(0, 8, 1'b0, 1'b0, 1'b1, 1, 32'h81, 32'h00, 99, r0, r1);
    repeat (8) @(negedge clk);
    checks++; if (rxv_cnt[0] - rb !== 1) begin fails++; $display("FAIL abort_next_pulses got=%0d want=1", rxv_cnt[0] - rb); end
    checks++; if (rx_d0 !== 8'h81) begin fails++; $display("FAIL abort_next_rx got=%h want=81", rx_d0); end
  endtask

  task automatic test_lsb16();
    logic [31:0] r0, r1;
    int rb;
    rb = rxv_cnt[3];
    push(3, 32'hBEEF);
    spi_frame(3, 16, 1'b0, 1'b0, 1'b0, 1, 32'h1234, 32'h0, 99, r0, r1);
    repeat (8) @(negedge clk);
    checks++; if (rxv_cnt[3] - rb !== 1) begin fails++; $display("FAIL lsb_rx_pulses got=%0d want=1", rxv_cnt[3] - rb); end
    checks++; if (rx_d3 !== 16'h1234) begin fails++; $display("FAIL lsb_rx_data got=%h want=1234", rx_d3); end
    checks++; if (r0 !== 32'hBEEF) begin fails++; $display("FAIL lsb_miso_word got=%h want=beef", r0); end
  endtask

  task automatic test_multi_slave();
    logic [31:0] r0, r1;
    int rb0, rb1, bad;
    logic mdone;
    rb0 = rxv_cnt[0];
    rb1 = rxv_cnt[1];
    bad = 0;
    mdone = 1'b0;
    push(0, 32'h5A);
    push(1, 32'hC3);
    fork
      begin
        spi_frame(1, 8, 1'b0, 1'b0, 1'b1, 1, 32'h96, 32'h00, 99, r0, r1);
        mdone = 1'b1;
      end
      begin
        for (int k = 0; k < 5000 && !mdone; k++) begin
          @(negedge clk);
          if (miso_w[0] !== 1'b0 || $isunknown(miso_bus)) bad++;
        end
      end
    join
    repeat (8) @(negedge clk);
    checks++; if (bad !== 0) begin fails++; $display("FAIL multi_desel_miso bad_samples got=%0d want=0", bad); end
    checks++; if (r0 !== 32'hC3) begin fails++; $display("FAIL multi_bus_word got=%h want=c3", r0); end
    checks++; if (rx_d1 !== 8'h96 || rxv_cnt[1] - rb1 !== 1) begin fails++; $display("FAIL multi_rx_sel got=%h/%0d want=96/1", rx_d1, rxv_cnt[1] - rb1); end
    checks++; if (rxv_cnt[0] - rb0 !== 0) begin fails++; $display("FAIL multi_rx_desel got=%0d want=0", rxv_cnt[0] - rb0); end
    checks++; if (tx_ready[0] !== 1'b0) begin fails++; $display("FAIL multi_desel_hold got=%b want=0", tx_ready[0]); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_back_to_back();
    test_abort();
    test_lsb16();
    test_multi_slave();
    checks++;
    if (ovr_cnt[0] + ovr_cnt[1] + ovr_cnt[2] + ovr_cnt[3] !== 0) begin
      fails++;
      $display("FAIL overrun_total got=%0d want=0", ovr_cnt[0] + ovr_cnt[1] + ovr_cnt[2] + ovr_cnt[3]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
